hamming_byte_encoder: RTL

//  Streaming Hamming(7,4) encoder feeding the Hamming decoder stage. Accepts bytes on a

---
 rtl/hamming_pkg.sv | 25 ++
 rtl/hamming74_enc.sv | 9 +
 rtl/hamming_byte_encoder.sv | 75 +++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming(7,4) positions, FSM encoding and codeword helpers.
package hamming_pkg;
    localparam int CW_W = 7;
    localparam int P1 = 1, P2 = 2, D1 = 3, P4 = 4, D2 = 5, D3 = 6, D4 = 7;

    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;

    function automatic logic [1:CW_W] encode74(input logic [3:0] n);
        logic [1:CW_W] c;
        c = '0;
        c[D1] = n[3];
        c[D2] = n[2];
        c[D3] = n[1];
        c[D4] = n[0];
        c[P1] = c[D1] ^ c[D2] ^ c[D4];
        c[P2] = c[D1] ^ c[D3] ^ c[D4];
        c[P4] = c[D2] ^ c[D3] ^ c[D4];
        return c;
    endfunction

    // Position 0 means "no injection"; positions 1..7 select c[1] (MSB) .. c[7].
    function automatic logic [1:CW_W] flip_mask(input logic [2:0] pos);
        return (pos == 3'd0) ? '0 : 7'b1000000 >> (pos - 3'd1);
    endfunction
endpackage

// File: rtl/hamming74_enc.sv
// hamming74_enc: combinational nibble to Hamming(7,4) codeword c[1:7].
module hamming74_enc
    import hamming_pkg::*;
(
    input  logic [3:0]      nibble,
    output logic [1:CW_W]   code
);
    assign code = encode74(nibble);
endmodule

// File: rtl/hamming_byte_encoder.sv
// hamming_byte_encoder: streams each byte out as two Hamming(7,4) codewords (high nibble first)
// with optional per-nibble single-bit error injection for exercising the downstream decoder.
module hamming_byte_encoder
    import hamming_pkg::*;
#(
    parameter int INJ_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [2:0]       inj_hi,
    input  logic [2:0]       inj_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:CW_W]    out_code,
    output logic             out_last,
    output logic [CNT_W-1:0] cw_count
);
    state_t state, state_nx;
    logic [7:0] data_q;
    logic [2:0] inj_hi_q, inj_lo_q;
    logic [1:CW_W] code_hi, code_lo;
    logic accept, xfer;

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

    hamming74_enc u_enc_hi (.nibble(data_q[7:4]), .code(code_hi));
    hamming74_enc u_enc_lo (.nibble(data_q[3:0]), .code(code_lo));

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE)    ? (in_valid ? SEND_HI : IDLE) :
                   (state == SEND_HI) ? (out_ready ? SEND_LO : SEND_HI) :
                   (state == SEND_LO) ? (out_ready ? (in_valid ? SEND_HI : IDLE) : SEND_LO) :
                   IDLE;
    end

    // in_ready never looks at in_valid, so upstream can't form a combinational loop through us.
    always_comb begin
        in_ready  = rst_n && ((state == IDLE) || (state == SEND_LO && out_ready));
        out_valid = (state == SEND_HI) || (state == SEND_LO);
        out_last  = (state == SEND_LO);
        out_code  = (state == SEND_HI) ? code_hi ^ flip_mask(inj_hi_q) :
                    (state == SEND_LO) ? code_lo ^ flip_mask(inj_lo_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q   <= '0;
            inj_hi_q <= '0;
            inj_lo_q <= '0;
        end else if (accept) begin
            data_q   <= in_data;
            inj_hi_q <= (INJ_EN != 0) ? inj_hi : 3'd0;
            inj_lo_q <= (INJ_EN != 0) ? inj_lo : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cw_count <= '0;
        else if (xfer)
            cw_count <= cw_count + 1'b1;
    end
endmodule
